dreg_slice_sequencer: RTL and testbench
=======================================

// Module: dreg_slice_sequencer
// PURPOSE
//  Data-register file plus a multi-cycle sequencer that runs D-register ALU ops of size
//  byte/word/long through a narrow ALU, one ALU_W-bit slice per cycle, carrying between slices.
//  Produces 68k-style condition codes. Sits between instruction decode and the data registers.
// PARAMETERS
//  DATA_W  32  register width; multiple of ALU_W
//  ALU_W   16  ALU slice width; 8, 16 or 32
//  NREGS   8   number of data registers; SEL width RW = $clog2(NREGS)
// PORTS
//  CLK        in   1      clock
//  RESET      in   1      synchronous, active-high reset
//  START      in   1      request op; sampled only in IDLE
//  OP         in   3      0 MOVE, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 EOR, 6 ADDX, 7 SUBX
//  SIZE       in   2      0 byte(8), 1 word(16), 2 long(32); 3 = long
//  SRC, DST   in   RW     operand registers; result is written to DST
//  LOAD_EN    in   1      direct register write, honoured only in IDLE
//  LOAD_SEL   in   RW     register to load
//  LOAD_DATA  in   DATA_W load value
//  DBG_SEL    in   RW     debug read select
//  DBG_DATA   out  DATA_W combinational read of DBG_SEL
//  BUSY       out  1      op in progress
//  DONE       out  1      one-cycle pulse; result and CCR already visible
//  CCR        out  5      {X,N,Z,V,C}
// BEHAVIOUR
//  - Reset: all registers 0, CCR 0, BUSY 0, DONE 0, state IDLE. Takes effect mid-op: op aborted, nothing written.
//  - States: IDLE -> LATCH -> SLICE (k cycles) -> WRITE -> IDLE.
//    k = max(1, sizebits/ALU_W); byte op with ALU_W>8 uses one slice.
//  - START taken in IDLE (including the DONE cycle); ignored while BUSY.
//  - LATCH captures SRC/DST values. LOAD and START together: load first, LATCH sees loaded value.
//  - LOAD_EN while BUSY is ignored; no register write.
//  - SLICE i: ALU on bits [i*ALU_W +: ALU_W]; carry-in = slice i-1 carry-out.
//    First carry-in: 0 for ADD; borrow 0 for SUB; X for ADDX/SUBX.
//  - SUB/SUBX compute DST - SRC.
//  - MOVE result = SRC.
//  - Size bits: result/flags use low sizebits only; DST bits above size are preserved.
//  - Byte op with ALU_W>8: C taken from sum bit 8, N from bit 7.
//  - WRITE: DST updated, CCR updated, DONE=1 on the following cycle, BUSY falls with it.
//  - Latency: START edge t -> DONE high after edge t+k+2. Long/16: 4 cycles; byte/word/16: 3 cycles.
//  - Flags for ADD/SUB: N = msb; Z = (result==0); V = signed overflow; C = carry/borrow; X = C.
//  - Flags for MOVE/AND/OR/EOR: N,Z as above; V=C=0; X unchanged.
//  - Flags for ADDX/SUBX: as ADD/SUB, except Z cleared if result!=0, else unchanged.
//  - SRC==DST is legal: operands are latched before write.
// CONFIGURATION
//  DREG_SEQ_EXTEND_EN defined: ADDX/SUBX as above.
//  Undefined: OP 6/7 take the full cycle count and pulse DONE, but write no register and leave CCR unchanged.
// STRUCTURE
//  Package dreg_seq_pkg holds: OP_* and SIZE_* codes, state encodings, CCR bit indices.
//  One sub-module, alu_slice: combinational, ALU_W-wide, inputs op/a/b/cin, outputs result/cout/ovf.
//  Sequencer, register file and CCR logic stay in this module.
// TESTING
//  - LOAD D0=1, D1=1; ADD.L SRC=1 DST=0 -> D0=2; DONE 4 cycles after START; CCR=0.
//  - D0=0x0000FFFF, D1=1; ADD.L -> D0=0x00010000; CCR=0; slice carry verified.
//  - D2=0x123456FF, D3=1; ADD.B DST=2 -> D2=0x12345600; X=Z=C=1; DONE after 3 cycles.
//  - D4=0, D5=1; SUB.L DST=4 -> D4=0xFFFFFFFF; X=N=C=1.
//  - D6=0x7FFFFFFF, D7=1; ADD.L -> D6=0x80000000; N=V=1.
//  - RESET during SLICE -> next cycle BUSY=0, DONE never pulses, all regs 0.
//  - START while BUSY -> ignored.
//  - With DREG_SEQ_EXTEND_EN: X=1, D0=0, D1=0; ADDX.L -> D0=1; Z unchanged.

Source files
------------

// File: rtl/dreg_slice_sequencer_pkg.sv
// dreg_seq_pkg: op and size codes, sequencer states and CCR bit positions shared by the
// dreg_slice_sequencer slice.
package dreg_seq_pkg;
    localparam logic [2:0] OP_MOVE = 3'd0, OP_ADD = 3'd1, OP_SUB = 3'd2, OP_AND = 3'd3;
    localparam logic [2:0] OP_OR = 3'd4, OP_EOR = 3'd5, OP_ADDX = 3'd6, OP_SUBX = 3'd7;
    localparam logic [1:0] SIZE_B = 2'd0, SIZE_W = 2'd1, SIZE_L = 2'd2;
    localparam int CCR_X = 4, CCR_N = 3, CCR_Z = 2, CCR_V = 1, CCR_C = 0;
    typedef enum logic [1:0] {ST_IDLE, ST_LATCH, ST_SLICE, ST_WRITE} state_t;
    function automatic logic [5:0] size_bits(input logic [1:0] size);
        return size == SIZE_B ? 6'd8 : size == SIZE_W ? 6'd16 : 6'd32;
    endfunction
endpackage

// File: rtl/dreg_slice_sequencer_if.sv
// dreg_slice_sequencer_if: decode-side op request, register load and debug read port.
interface dreg_slice_sequencer_if #(parameter int DATA_W = 32, NREGS = 8, RW = $clog2(NREGS));
    logic              START;
    logic [2:0]        OP;
    logic [1:0]        SIZE;
    logic [RW-1:0]     SRC, DST;
    logic              LOAD_EN;
    logic [RW-1:0]     LOAD_SEL;
    logic [DATA_W-1:0] LOAD_DATA;
    logic [RW-1:0]     DBG_SEL;
    logic [DATA_W-1:0] DBG_DATA;
    logic              BUSY, DONE;
    logic [4:0]        CCR;
    modport master (output START, OP, SIZE, SRC, DST, LOAD_EN, LOAD_SEL, LOAD_DATA, DBG_SEL,
                    input DBG_DATA, BUSY, DONE, CCR);
    modport slave (input START, OP, SIZE, SRC, DST, LOAD_EN, LOAD_SEL, LOAD_DATA, DBG_SEL,
                   output DBG_DATA, BUSY, DONE, CCR);
endinterface

// File: rtl/dreg_slice_sequencer_alu_slice.sv
// alu_slice: one ALU_W-bit slice of the D-register ALU; a is the destination operand, b the source.
module alu_slice import dreg_seq_pkg::*; #(parameter int ALU_W = 16) (
    input  logic [2:0]       op,
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    input  logic             cin,
    output logic [ALU_W-1:0] result,
    output logic             cout,
    output logic             ovf
);
    logic [ALU_W:0] sum, dif;
    logic add, sub;
    always_comb begin
        sum = {1'b0, a} + {1'b0, b} + {{ALU_W{1'b0}}, cin};
        dif = {1'b0, a} - {1'b0, b} - {{ALU_W{1'b0}}, cin};
        add = op == OP_ADD || op == OP_ADDX;
        sub = op == OP_SUB || op == OP_SUBX;
        result = op == OP_MOVE ? b : op == OP_AND ? a & b : op == OP_OR ? a | b :
                 op == OP_EOR ? a ^ b : sub ? dif[ALU_W-1:0] : sum[ALU_W-1:0];
        cout = add ? sum[ALU_W] : sub & dif[ALU_W];
        ovf = (add | sub) & (sub ? a[ALU_W-1] ^ b[ALU_W-1] : ~(a[ALU_W-1] ^ b[ALU_W-1]))
              & (result[ALU_W-1] ^ a[ALU_W-1]);
    end
endmodule

// File: rtl/dreg_slice_sequencer.sv
// dreg_slice_sequencer: D-register file with a sequencer running byte/word/long ops through an ALU_W slice.
// Define DREG_SEQ_EXTEND_EN to enable ADDX/SUBX; otherwise they run as timed no-ops.
module dreg_slice_sequencer import dreg_seq_pkg::*; #(
    parameter int DATA_W = 32,
    parameter int ALU_W  = 16,
    parameter int NREGS  = 8
) (
    input logic CLK,
    input logic RESET,
    dreg_slice_sequencer_if.slave bus
);
    localparam int RW = $clog2(NREGS);
    state_t state, nxt;
    logic [DATA_W-1:0] regs [NREGS];
    logic [2:0] op_q;
    logic [1:0] size_q;
    logic [RW-1:0] src_q, dst_q;
    logic [DATA_W-1:0] a_q, b_q, res_q, mask, wr_val;
    logic [DATA_W:0] r_ext, a_ext, b_ext;
    logic [5:0] idx, sb, nsl;
    logic carry_q, ovf_q, done_q;
    logic [4:0] ccr, ccr_nxt, ccr_x;
    logic [ALU_W-1:0] a_sl, b_sl, r_sl;
    logic c_sl, v_sl, n, z, v, c, narrow, is_x, is_sub, wr_en;
    alu_slice #(.ALU_W(ALU_W)) u_alu (
        .op(op_q), .a(a_sl), .b(b_sl), .cin(carry_q), .result(r_sl), .cout(c_sl), .ovf(v_sl)
    );
    always_comb begin
        sb = size_bits(size_q);
        mask = sb >= 6'(DATA_W) ? '1 : (DATA_W'(1) << sb) - DATA_W'(1);
        nsl = sb < 6'(ALU_W) ? 6'd1 : sb / 6'(ALU_W);
        a_sl = ALU_W'(a_q >> (idx * 6'(ALU_W)));
        b_sl = ALU_W'(b_q >> (idx * 6'(ALU_W)));
        nxt = state == ST_IDLE ? (bus.START ? ST_LATCH : ST_IDLE) :
              state == ST_LATCH ? ST_SLICE :
              state == ST_SLICE ? (idx == nsl - 6'd1 ? ST_WRITE : ST_SLICE) : ST_IDLE;
    end
    // Operands are zero-extended above the op size, so a narrow op's carry lands in result bit sb.
    always_comb begin
        is_x = op_q == OP_ADDX || op_q == OP_SUBX;
        is_sub = op_q == OP_SUB || op_q == OP_SUBX;
        r_ext = {1'b0, res_q};
        a_ext = {1'b0, a_q};
        b_ext = {1'b0, b_q};
        narrow = sb < 6'(ALU_W);
        n = r_ext[sb - 6'd1];
        z = (res_q & mask) == '0;
        c = narrow ? r_ext[sb] : carry_q;
        v = narrow ? (is_sub ? a_ext[sb - 6'd1] ^ b_ext[sb - 6'd1] : ~(a_ext[sb - 6'd1] ^ b_ext[sb - 6'd1]))
                     & (r_ext[sb - 6'd1] ^ a_ext[sb - 6'd1]) : ovf_q;
`ifdef DREG_SEQ_EXTEND_EN
        wr_en = 1'b1;
        ccr_x = {c, n, z & ccr[CCR_Z], v, c};
`else
        wr_en = !is_x;
        ccr_x = ccr;
`endif
        ccr_nxt = is_x ? ccr_x : (op_q == OP_ADD || op_q == OP_SUB) ? {c, n, z, v, c} :
                  {ccr[CCR_X], n, z, 2'b00};
        wr_val = (regs[dst_q] & ~mask) | (res_q & mask);
    end
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= ST_IDLE;
            done_q <= 1'b0;
            ccr <= '0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            state <= nxt;
            done_q <= state == ST_WRITE;
            if (state == ST_IDLE && bus.LOAD_EN) regs[bus.LOAD_SEL] <= bus.LOAD_DATA;
            if (state == ST_IDLE && bus.START) begin
                op_q <= bus.OP;
                size_q <= bus.SIZE;
                src_q <= bus.SRC;
                dst_q <= bus.DST;
            end
            if (state == ST_LATCH) begin
                a_q <= regs[dst_q] & mask;
                b_q <= regs[src_q] & mask;
                res_q <= '0;
                idx <= '0;
                carry_q <= is_x & ccr[CCR_X];
                ovf_q <= 1'b0;
            end
            if (state == ST_SLICE) begin
                res_q <= res_q | (DATA_W'(r_sl) << (idx * 6'(ALU_W)));
                carry_q <= c_sl;
                ovf_q <= v_sl;
                idx <= idx + 6'd1;
            end
            if (state == ST_WRITE) begin
                if (wr_en) regs[dst_q] <= wr_val;
                ccr <= ccr_nxt;
            end
        end
    end
    assign bus.BUSY = state != ST_IDLE;
    assign bus.DONE = done_q;
    assign bus.CCR = ccr;
    assign bus.DBG_DATA = regs[bus.DBG_SEL];
endmodule

// File: tb/tb_dreg_slice_sequencer.sv
// tb_dreg_slice_sequencer: directed and random ops checked against an arithmetic model of
// the register file and condition codes.
module tb_dreg_slice_sequencer;
    localparam int ALU_W = 16;
    logic CLK = 1'b0;
    logic RESET = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [31:0] mregs [8];
    logic [4:0] mccr;
    dreg_slice_sequencer_if #(.DATA_W(32), .NREGS(8)) bus ();
    dreg_slice_sequencer #(.DATA_W(32), .ALU_W(ALU_W), .NREGS(8)) dut (
        .CLK(CLK), .RESET(RESET), .bus(bus)
    );
    always #5 CLK = ~CLK;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    // Flags from signed/unsigned arithmetic on the sized operands.
    task automatic model_exec(input logic [2:0] op, input logic [1:0] sz, input logic [2:0] s, input logic [2:0] d);
        longint sb, m, half, a, b, x, t, sa, sbv, full, sig, r;
        logic n, z, v, c, wr;
        sb = sz == 2'd0 ? 8 : sz == 2'd1 ? 16 : 32;
        m = (longint'(1) << sb) - 1;
        half = (m + 1) / 2;
        a = longint'(mregs[d]) & m;
        b = longint'(mregs[s]) & m;
        x = longint'(mccr[4]);
        sa = a >= half ? a - (m + 1) : a;
        sbv = b >= half ? b - (m + 1) : b;
        t = (op == 3'd6 || op == 3'd7) ? x : 0;
        v = 1'b0;
        c = 1'b0;
        wr = 1'b1;
        case (op)
            3'd1, 3'd6: begin
                full = a + b + t;
                sig = sa + sbv + t;
                c = full > m;
                v = sig >= half || sig < -half;
                r = full & m;
            end
            3'd2, 3'd7: begin
                full = a - b - t;
                sig = sa - sbv - t;
                c = full < 0;
                v = sig >= half || sig < -half;
                r = full & m;
            end
            3'd0: r = b;
            3'd3: r = a & b;
            3'd4: r = a | b;
            default: r = a ^ b;
        endcase
        n = ((r >> (sb - 1)) & 1) != 0;
        z = r == 0;
        case (op)
            3'd1, 3'd2: mccr = {c, n, z, v, c};
            3'd6, 3'd7: begin
`ifdef DREG_SEQ_EXTEND_EN
                mccr = {c, n, z & mccr[2], v, c};
`else
                wr = 1'b0;
`endif
            end
            default: mccr = {mccr[4], n, z, 2'b00};
        endcase
        if (wr) mregs[d] = (mregs[d] & ~32'(m)) | 32'(r);
    endtask
    task automatic load(input logic [2:0] sel, input logic [31:0] dat);
        @(negedge CLK);
        bus.LOAD_EN = 1'b1;
        bus.LOAD_SEL = sel;
        bus.LOAD_DATA = dat;
        @(posedge CLK);
        #1 bus.LOAD_EN = 1'b0;
        mregs[sel] = dat;
    endtask
    task automatic dbg_is(input string tag, input logic [2:0] sel, input logic [31:0] exp);
        bus.DBG_SEL = sel;
        #1 check(tag, bus.DBG_DATA, exp);
    endtask
    task automatic sweep(input string tag);
        for (int i = 0; i < 8; i++) dbg_is(tag, 3'(i), mregs[i]);
    endtask
    task automatic do_op(input logic [2:0] op, input logic [1:0] sz, input logic [2:0] s, input logic [2:0] d,
                         input bit ld, input logic [2:0] lsel, input logic [31:0] ldat, input bit poke);
        int n, sb, k;
        @(negedge CLK);
        bus.START = 1'b1;
        bus.OP = op;
        bus.SIZE = sz;
        bus.SRC = s;
        bus.DST = d;
        bus.LOAD_EN = ld;
        bus.LOAD_SEL = lsel;
        bus.LOAD_DATA = ldat;
        @(posedge CLK);
        #1 bus.START = 1'b0;
        bus.LOAD_EN = 1'b0;
        if (ld) mregs[lsel] = ldat;
        model_exec(op, sz, s, d);
        check("busy_on", bus.BUSY, 1);
        n = 0;
        while (n < 20) begin
            if (poke && n == 0) begin
                bus.START = 1'b1;
                bus.OP = 3'($urandom);
                bus.SRC = 3'($urandom);
                bus.DST = d + 3'd1;
                bus.LOAD_EN = 1'b1;
                bus.LOAD_SEL = d + 3'd1;
                bus.LOAD_DATA = $urandom;
            end
            @(posedge CLK);
            n++;
            #1 bus.START = 1'b0;
            bus.LOAD_EN = 1'b0;
            if (bus.DONE) break;
        end
        sb = sz == 2'd0 ? 8 : sz == 2'd1 ? 16 : 32;
        k = sb / ALU_W < 1 ? 1 : sb / ALU_W;
        check("latency", n, k + 2);
        check("busy_off", bus.BUSY, 0);
        dbg_is("dst", d, mregs[d]);
        check("ccr", bus.CCR, mccr);
    endtask
    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h0000_FFFF;
            default: return $urandom;
        endcase
    endfunction
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
    initial begin
        bit seen;
        bus.START = 1'b0;
        bus.OP = '0;
        bus.SIZE = '0;
        bus.SRC = '0;
        bus.DST = '0;
        bus.LOAD_EN = 1'b0;
        bus.LOAD_SEL = '0;
        bus.LOAD_DATA = '0;
        bus.DBG_SEL = '0;
        for (int i = 0; i < 8; i++) mregs[i] = '0;
        mccr = '0;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        check("rst_busy", bus.BUSY, 0);
        check("rst_done", bus.DONE, 0);
        check("rst_ccr", bus.CCR, 0);
        sweep("rst_reg");
        load(0, 32'd1);
        load(1, 32'd1);
        do_op(3'd1, 2'd2, 1, 0, 0, 0, 0, 0);
        dbg_is("add_l", 0, 32'd2);
        check("add_l_ccr", bus.CCR, 5'b00000);
        load(0, 32'h0000_FFFF);
        do_op(3'd1, 2'd2, 1, 0, 0, 0, 0, 0);
        dbg_is("add_l_carry", 0, 32'h0001_0000);
        check("add_l_carry_ccr", bus.CCR, 5'b00000);
        load(4, 32'd0);
        load(5, 32'd1);
        do_op(3'd2, 2'd2, 5, 4, 0, 0, 0, 0);
        dbg_is("sub_l", 4, 32'hFFFF_FFFF);
        check("sub_l_ccr", bus.CCR, 5'b11001);
        load(0, 32'd0);
        load(1, 32'd0);
        do_op(3'd6, 2'd2, 1, 0, 0, 0, 0, 0);
`ifdef DREG_SEQ_EXTEND_EN
        dbg_is("addx_l", 0, 32'd1);
        check("addx_l_ccr", bus.CCR, 5'b00000);
`else
        dbg_is("addx_off", 0, 32'd0);
        check("addx_off_ccr", bus.CCR, 5'b11001);
`endif
        load(2, 32'h1234_56FF);
        load(3, 32'd1);
        do_op(3'd1, 2'd0, 3, 2, 0, 0, 0, 0);
        dbg_is("add_b", 2, 32'h1234_5600);
        check("add_b_ccr", bus.CCR, 5'b10101);
        load(6, 32'h7FFF_FFFF);
        load(7, 32'd1);
        do_op(3'd1, 2'd2, 7, 6, 0, 0, 0, 0);
        dbg_is("add_l_ovf", 6, 32'h8000_0000);
        check("add_l_ovf_ccr", bus.CCR, 5'b01010);
        do_op(3'd0, 2'd1, 1, 2, 1, 1, 32'hABCD_1234, 0);
        dbg_is("load_start_move_w", 2, 32'h1234_1234);
        do_op(3'd1, 2'd1, 6, 7, 0, 0, 0, 1);
        @(posedge CLK);
        #1 check("done_pulse", bus.DONE, 0);
        check("busy_ignored_start", bus.BUSY, 0);
        sweep("busy_ignored_load");
        @(negedge CLK);
        bus.START = 1'b1;
        bus.OP = 3'd1;
        bus.SIZE = 2'd2;
        bus.SRC = 3'd7;
        bus.DST = 3'd6;
        @(posedge CLK);
        #1 bus.START = 1'b0;
        @(posedge CLK);
        #1 RESET = 1'b1;
        @(posedge CLK);
        #1 RESET = 1'b0;
        check("rst_mid_busy", bus.BUSY, 0);
        seen = 1'b0;
        repeat (6) begin
            if (bus.DONE) seen = 1'b1;
            @(posedge CLK);
            #1;
        end
        check("rst_mid_done", seen, 0);
        for (int i = 0; i < 8; i++) mregs[i] = '0;
        mccr = '0;
        check("rst_mid_ccr", bus.CCR, 0);
        sweep("rst_mid_reg");
        for (int it = 0; it < 80; it++) begin
            if ($urandom_range(0, 1) == 0) load(3'($urandom_range(0, 7)), pick_val());
            do_op(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), $urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)),
                  pick_val(), $urandom_range(0, 4) == 0);
        end
        sweep("final_reg");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
